// File: rtl/kyber_pkg.sv
// Kyber constants, decompressor FSM encoding and the
// scalar rounding helper shared by the decompress lanes.
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int DATA_WIDTH = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // round(c * q / 2^d), with ties rounding up
  function automatic logic [DATA_WIDTH-1:0] decompress_d(
    input logic [10:0] c,
    input int unsigned d
  );
    logic [31:0] p;
    p = 32'(c) * 32'(KYBER_Q) + (32'd1 << (d - 1));
    return DATA_WIDTH'(p >> d);
  endfunction

endpackage

// File: rtl/coeff_decompress.sv
// One combinational decompress lane: D_BITS-bit compressed
// coefficient in, DATA_WIDTH-bit coefficient mod q out.
module coeff_decompress
  import kyber_pkg::*;
#(
  parameter int D_BITS = 3
) (
  input  logic [D_BITS-1:0]     c,
  output logic [DATA_WIDTH-1:0] y
);

  assign y = decompress_d(11'(c), D_BITS);

endmodule

// File: rtl/poly_decompress_stream.sv
// Streaming Kyber polynomial decompressor, LANES coeffs per beat.
// Define POLY_DECOMPRESS_FULLVEC_EN to add the oPoly full-vector port.
module poly_decompress_stream
  import kyber_pkg::*;
#(
  parameter int D_BITS = 3,
  parameter int LANES  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [D_BITS*KYBER_N-1:0]     iPoly_Compressed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   oCoeffs,
  output logic                          out_last,
  output logic                          done
`ifdef POLY_DECOMPRESS_FULLVEC_EN
  ,
  output logic [KYBER_N*DATA_WIDTH-1:0] oPoly
`endif
);

  localparam int IN_WIDTH  = D_BITS * KYBER_N;
  localparam int BEAT_BITS = D_BITS * LANES;
  localparam int BEAT_W    = LANES * DATA_WIDTH;
  localparam int BEATS     = KYBER_N / LANES;
  localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int REM_W     = (BEATS > 1) ? IN_WIDTH - BEAT_BITS : 1;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        beat_q;
  logic                 valid_q;
  logic                 done_q;
  logic [BEAT_W-1:0]    coeffs_q;
  logic [BEAT_W-1:0]    coeffs_d;
  logic [BEAT_BITS-1:0] lane_src;
  logic [BEAT_BITS-1:0] next_src;
  logic                 load;
  logic                 adv;
  logic                 fin;
  logic                 hs;
  logic                 at_last;

  assign hs      = valid_q && out_ready;
  assign at_last = (beat_q == CW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (at_last) begin
            fin     = 1'b1;
            state_d = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
    endcase
  end

  // Beat 0 comes straight from the input; the rest of the
  // polynomial waits in the shift register, next beat lowest.
  if (BEATS > 1) begin : g_sreg
    logic [REM_W-1:0] sreg_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sreg_q <= '0;
      end else if (load) begin
        sreg_q <= iPoly_Compressed[IN_WIDTH-1:BEAT_BITS];
      end else if (adv) begin
        sreg_q <= sreg_q >> BEAT_BITS;
      end
    end

    assign next_src = sreg_q[BEAT_BITS-1:0];
  end else begin : g_nosreg
    assign next_src = '0;
  end

  assign lane_src = load ? iPoly_Compressed[BEAT_BITS-1:0]
                         : next_src;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    coeff_decompress #(
      .D_BITS(D_BITS)
    ) u_dec (
      .c(lane_src[j*D_BITS +: D_BITS]),
      .y(coeffs_d[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      coeffs_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      if (load) begin
        valid_q  <= 1'b1;
        beat_q   <= '0;
        coeffs_q <= coeffs_d;
      end else if (adv) begin
        beat_q   <= beat_q + CW'(1);
        coeffs_q <= coeffs_d;
      end else if (fin) begin
        valid_q <= 1'b0;
        beat_q  <= '0;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign oCoeffs   = coeffs_q;
  assign out_last  = valid_q && at_last;
  assign done      = done_q;

`ifdef POLY_DECOMPRESS_FULLVEC_EN
  logic [KYBER_N*DATA_WIDTH-1:0] poly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      poly_q <= '0;
    end else if (hs) begin
      poly_q[int'(beat_q)*BEAT_W +: BEAT_W] <= coeffs_q;
    end
  end

  assign oPoly = poly_q;
`else
  // Beats are visible only on oCoeffs in this build.
`endif

endmodule
